pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 The block SHALL have one clock and reset is asynchronous and active-low; the ports SHALL be clk and rst, with rst=0 resetting and rst=1 running.
REQ-002 The ports SHALL be, clock and reset first:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  async active-low reset
- rs1D  in  5  source reg 1 of the instruction in Decode
- rs2D  in  5  source reg 2 of the instruction in Decode
- rdD  in  5  destination reg of the instruction in Decode
- regwriteD  in  1  Decode instruction writes the register file
- memreadD  in  1  Decode instruction is a load
- pcsrcE  in  1  branch/jump taken, resolved in Execute
- rs1E, rs2E, rdE  out  5 each  Execute-stage register fields
- regwriteE, memreadE  out  1 each  Execute-stage controls
- rdM, regwriteM  out  5/1  Memory-stage fields
- rdW, regwriteW  out  5/1  Writeback-stage fields
- stallF, stallD  out  1 each  hold the PC and the IF/ID register
- flushD, flushE  out  1 each  clear the IF/ID and ID/EX registers
- lwstall_cnt  out  16  count of load-use stall cycles, saturating
- flush_cnt  out  16  count of taken-branch flush cycles, saturating

Function
REQ-003 The Execute stage SHALL register rs1D, rs2D, rdD, regwriteD and memreadD into rs1E, rs2E, rdE, regwriteE and memreadE on each rising edge of clk.
REQ-004 When flushE=1 at a rising edge, the Execute stage SHALL capture all zeros instead of the Decode values; flushE SHALL have priority over the load.
REQ-005 The block SHALL advance rdE/regwriteE into rdM/regwriteM, and rdM/regwriteM into rdW/regwriteW, every cycle unconditionally; the M and W stages SHALL have no stall and no flush.
REQ-006 Internal lwstall SHALL be combinational and equal to memreadE & regwriteE & (rdE!=0) & ((rdE==rs1D) | (rdE==rs2D)).
REQ-007 stallF and stallD SHALL both equal lwstall & ~pcsrcE, so a taken branch overrides a load-use stall.
REQ-008 flushD SHALL equal pcsrcE.
REQ-009 flushE SHALL equal lwstall | pcsrcE.
REQ-010 A load-use stall SHALL last exactly one cycle: the bubble clears memreadE, so lwstall deasserts in the next cycle.
REQ-011 The forwarding unit SHALL consume rs1E, rs2E, rdM, regwriteM, rdW and regwriteW directly; these outputs SHALL be registers with no combinational path from the inputs.
REQ-012 lwstall_cnt SHALL increment by 1 on each rising edge where stallD=1, and SHALL hold at 16'hFFFF once reached, with no wrap.
REQ-013 flush_cnt SHALL increment by 1 on each rising edge where pcsrcE=1, saturating at 16'hFFFF.
REQ-014 When lwstall and pcsrcE are both 1, flush_cnt SHALL increment, lwstall_cnt SHALL NOT increment, and flushD and flushE SHALL both be 1.
REQ-015 A register index of 0 SHALL never cause a stall, even for a load to x0.

Reset
REQ-016 While rst=0, every register (E, M, W fields and both counters) SHALL be 0 immediately, without waiting for a clock edge.
REQ-017 While rst=0, stallF and stallD SHALL be 0; flushD and flushE SHALL follow pcsrcE combinationally.
REQ-018 The first capture after release SHALL be the first rising edge with rst=1.
REQ-019 A reset asserted mid-stall SHALL abort the stall in the same cycle, and the bubble SHALL NOT persist after release.

Verification
REQ-020 Load-use: the bench SHALL drive a load with rdD=5, memreadD=1, regwriteD=1, then next cycle rs1D=5 -> stallF=stallD=flushE=1 for exactly one cycle, rdE=0 after the edge, and lwstall_cnt=1.
REQ-021 No hazard: the bench SHALL drive a load to rd=5 followed by an instruction with rs1D=6, rs2D=7 -> no stall, and the pipeline SHALL shift so that rdM=5 one cycle and rdW=5 two cycles after the load reaches E.
REQ-022 x0 load: the bench SHALL drive a load with rdD=0 followed by rs1D=0 -> stallD=0 and lwstall_cnt unchanged.
REQ-023 Branch: the bench SHALL drive pcsrcE=1 for one cycle -> flushD=flushE=1 and stallD=0, the E fields SHALL be zero after the edge, and flush_cnt SHALL increment by 1.
REQ-024 Simultaneous: the bench SHALL force a load-use condition together with pcsrcE=1 -> stallF=0, flushD=flushE=1, lwstall_cnt unchanged, and flush_cnt+1.
REQ-025 Async reset: the bench SHALL pulse rst low between clock edges while lwstall=1 -> all registered outputs SHALL be 0 before the next edge; a further scenario SHALL preload lwstall_cnt to 16'hFFFF, hold a stall, and check the count stays at 16'hFFFF.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// Decode-to-Execute hazard bundle: Decode fields and branch outcome in,
// pipeline fields, stall/flush controls and event counters out.
interface pipe_hazard_ctrl_if;
   logic [4:0]  rs1D;
   logic [4:0]  rs2D;
   logic [4:0]  rdD;
   logic        regwriteD;
   logic        memreadD;
   logic        pcsrcE;
   logic [4:0]  rs1E;
   logic [4:0]  rs2E;
   logic [4:0]  rdE;
   logic        regwriteE;
   logic        memreadE;
   logic [4:0]  rdM;
   logic        regwriteM;
   logic [4:0]  rdW;
   logic        regwriteW;
   logic        stallF;
   logic        stallD;
   logic        flushD;
   logic        flushE;
   logic [15:0] lwstall_cnt;
   logic [15:0] flush_cnt;

   modport master (
      output rs1D, rs2D, rdD, regwriteD, memreadD, pcsrcE,
      input  rs1E, rs2E, rdE, regwriteE, memreadE,
      input  rdM, regwriteM, rdW, regwriteW,
      input  stallF, stallD, flushD, flushE,
      input  lwstall_cnt, flush_cnt
   );

   modport slave (
      input  rs1D, rs2D, rdD, regwriteD, memreadD, pcsrcE,
      output rs1E, rs2E, rdE, regwriteE, memreadE,
      output rdM, regwriteM, rdW, regwriteW,
      output stallF, stallD, flushD, flushE,
      output lwstall_cnt, flush_cnt
   );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Load-use stall / branch flush control with E, M, W register tracking
// and saturating stall and flush event counters.
module pipe_hazard_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  rs1D,
   input  logic [4:0]  rs2D,
   input  logic [4:0]  rdD,
   input  logic        regwriteD,
   input  logic        memreadD,
   input  logic        pcsrcE,
   output logic [4:0]  rs1E,
   output logic [4:0]  rs2E,
   output logic [4:0]  rdE,
   output logic        regwriteE,
   output logic        memreadE,
   output logic [4:0]  rdM,
   output logic        regwriteM,
   output logic [4:0]  rdW,
   output logic        regwriteW,
   output logic        stallF,
   output logic        stallD,
   output logic        flushD,
   output logic        flushE,
   output logic [15:0] lwstall_cnt,
   output logic [15:0] flush_cnt
);
   localparam logic [15:0] CNT_MAX = 16'hFFFF;

   logic [4:0]  rs1E_q, rs1E_d;
   logic [4:0]  rs2E_q, rs2E_d;
   logic [4:0]  rdE_q, rdE_d;
   logic        regwriteE_q, regwriteE_d;
   logic        memreadE_q, memreadE_d;
   logic [4:0]  rdM_q;
   logic        regwriteM_q;
   logic [4:0]  rdW_q;
   logic        regwriteW_q;
   logic [15:0] lwstall_cnt_q, lwstall_cnt_d;
   logic [15:0] flush_cnt_q, flush_cnt_d;
   logic        lwstall;
   logic        stall;
   logic        flush_e;

   // x0 is never a real producer, so it cannot create a hazard
   assign lwstall = memreadE_q & regwriteE_q & (rdE_q != 5'd0) &
                    ((rdE_q == rs1D) | (rdE_q == rs2D));
   assign stall   = lwstall & ~pcsrcE;
   assign flush_e = lwstall | pcsrcE;

   always_comb begin
      rs1E_d      = rs1D;
      rs2E_d      = rs2D;
      rdE_d       = rdD;
      regwriteE_d = regwriteD;
      memreadE_d  = memreadD;
      if (flush_e) begin
         rs1E_d      = 5'd0;
         rs2E_d      = 5'd0;
         rdE_d       = 5'd0;
         regwriteE_d = 1'b0;
         memreadE_d  = 1'b0;
      end
   end

   always_comb begin
      lwstall_cnt_d = lwstall_cnt_q;
      flush_cnt_d   = flush_cnt_q;
      if (stall && lwstall_cnt_q != CNT_MAX)
         lwstall_cnt_d = lwstall_cnt_q + 16'd1;
      if (pcsrcE && flush_cnt_q != CNT_MAX)
         flush_cnt_d = flush_cnt_q + 16'd1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rs1E_q        <= 5'd0;
         rs2E_q        <= 5'd0;
         rdE_q         <= 5'd0;
         regwriteE_q   <= 1'b0;
         memreadE_q    <= 1'b0;
         rdM_q         <= 5'd0;
         regwriteM_q   <= 1'b0;
         rdW_q         <= 5'd0;
         regwriteW_q   <= 1'b0;
         lwstall_cnt_q <= 16'd0;
         flush_cnt_q   <= 16'd0;
      end else begin
         rs1E_q        <= rs1E_d;
         rs2E_q        <= rs2E_d;
         rdE_q         <= rdE_d;
         regwriteE_q   <= regwriteE_d;
         memreadE_q    <= memreadE_d;
         rdM_q         <= rdE_q;
         regwriteM_q   <= regwriteE_q;
         rdW_q         <= rdM_q;
         regwriteW_q   <= regwriteM_q;
         lwstall_cnt_q <= lwstall_cnt_d;
         flush_cnt_q   <= flush_cnt_d;
      end
   end

   assign rs1E        = rs1E_q;
   assign rs2E        = rs2E_q;
   assign rdE         = rdE_q;
   assign regwriteE   = regwriteE_q;
   assign memreadE    = memreadE_q;
   assign rdM         = rdM_q;
   assign regwriteM   = regwriteM_q;
   assign rdW         = rdW_q;
   assign regwriteW   = regwriteW_q;
   assign stallF      = stall;
   assign stallD      = stall;
   assign flushD      = pcsrcE;
   assign flushE      = flush_e;
   assign lwstall_cnt = lwstall_cnt_q;
   assign flush_cnt   = flush_cnt_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed scoreboard bench for pipe_hazard_ctrl: the driver queues
// hand-computed expectations, the monitor checks them on the falling edge.
module tb_pipe_hazard_ctrl;
   logic clk;
   logic rst;

   pipe_hazard_ctrl_if bus ();

   pipe_hazard_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .rs1D        (bus.rs1D),
      .rs2D        (bus.rs2D),
      .rdD         (bus.rdD),
      .regwriteD   (bus.regwriteD),
      .memreadD    (bus.memreadD),
      .pcsrcE      (bus.pcsrcE),
      .rs1E        (bus.rs1E),
      .rs2E        (bus.rs2E),
      .rdE         (bus.rdE),
      .regwriteE   (bus.regwriteE),
      .memreadE    (bus.memreadE),
      .rdM         (bus.rdM),
      .regwriteM   (bus.regwriteM),
      .rdW         (bus.rdW),
      .regwriteW   (bus.regwriteW),
      .stallF      (bus.stallF),
      .stallD      (bus.stallD),
      .flushD      (bus.flushD),
      .flushE      (bus.flushE),
      .lwstall_cnt (bus.lwstall_cnt),
      .flush_cnt   (bus.flush_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef enum int {
      F_RS1E, F_RS2E, F_RDE, F_RWE, F_MRE, F_RDM, F_RWM,
      F_RDW, F_RWW, F_STF, F_STD, F_FLD, F_FLE, F_LWC, F_FLC
   } field_t;

   typedef struct {
      string       name;
      field_t      fld;
      logic [15:0] val;
   } exp_t;

   exp_t exp_q[$];
   int   checks;
   int   failures;
   bit   done;

   function automatic logic [15:0] get(field_t f);
      case (f)
         F_RS1E:  return {11'd0, bus.rs1E};
         F_RS2E:  return {11'd0, bus.rs2E};
         F_RDE:   return {11'd0, bus.rdE};
         F_RWE:   return {15'd0, bus.regwriteE};
         F_MRE:   return {15'd0, bus.memreadE};
         F_RDM:   return {11'd0, bus.rdM};
         F_RWM:   return {15'd0, bus.regwriteM};
         F_RDW:   return {11'd0, bus.rdW};
         F_RWW:   return {15'd0, bus.regwriteW};
         F_STF:   return {15'd0, bus.stallF};
         F_STD:   return {15'd0, bus.stallD};
         F_FLD:   return {15'd0, bus.flushD};
         F_FLE:   return {15'd0, bus.flushE};
         F_LWC:   return bus.lwstall_cnt;
         default: return bus.flush_cnt;
      endcase
   endfunction

   task automatic ex(string n, field_t f, logic [15:0] v);
      exp_t e;
      e.name = n;
      e.fld  = f;
      e.val  = v;
      exp_q.push_back(e);
   endtask

   task automatic drv(logic [4:0] r1, logic [4:0] r2, logic [4:0] rd,
                      logic rw, logic mr, logic pc);
      bus.rs1D      = r1;
      bus.rs2D      = r2;
      bus.rdD       = rd;
      bus.regwriteD = rw;
      bus.memreadD  = mr;
      bus.pcsrcE    = pc;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // monitor: every queued expectation is due at the next falling edge
   always @(negedge clk) begin
      while (exp_q.size() > 0) begin
         exp_t e;
         logic [15:0] a;
         e = exp_q.pop_front();
         a = get(e.fld);
         checks++;
         if (a !== e.val) begin
            failures++;
            $display("FAIL %s: got %h expected %h", e.name, a, e.val);
         end
      end
   end

   initial begin
      checks   = 0;
      failures = 0;
      done     = 1'b0;
      rst      = 1'b0;
      drv(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      #1;
      // reset: registers cleared, flushes follow pcsrcE, no stall
      bus.pcsrcE = 1'b1;
      ex("rst_rdE", F_RDE, 16'd0);
      ex("rst_rwE", F_RWE, 16'd0);
      ex("rst_rdW", F_RDW, 16'd0);
      ex("rst_stallF", F_STF, 16'd0);
      ex("rst_stallD", F_STD, 16'd0);
      ex("rst_flushD", F_FLD, 16'd1);
      ex("rst_flushE", F_FLE, 16'd1);
      ex("rst_lwcnt", F_LWC, 16'd0);
      ex("rst_flcnt", F_FLC, 16'd0);
      @(negedge clk);
      #2;
      rst = 1'b1;
      drv(5'd1, 5'd2, 5'd5, 1'b1, 1'b1, 1'b0);
      // load to x5 in E, consumer in D
      step();
      drv(5'd5, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0);
      ex("lu_rdE", F_RDE, 16'd5);
      ex("lu_mrE", F_MRE, 16'd1);
      ex("lu_stallF", F_STF, 16'd1);
      ex("lu_stallD", F_STD, 16'd1);
      ex("lu_flushE", F_FLE, 16'd1);
      ex("lu_flushD", F_FLD, 16'd0);
      ex("lu_cnt0", F_LWC, 16'd0);
      step();
      ex("bub_rdE", F_RDE, 16'd0);
      ex("bub_rwE", F_RWE, 16'd0);
      ex("bub_stallD", F_STD, 16'd0);
      ex("bub_flushE", F_FLE, 16'd0);
      ex("bub_cnt1", F_LWC, 16'd1);
      ex("bub_rdM", F_RDM, 16'd5);
      ex("bub_rwM", F_RWM, 16'd1);
      step();
      drv(5'd3, 5'd4, 5'd5, 1'b1, 1'b1, 1'b0);
      ex("rel_rdE", F_RDE, 16'd7);
      ex("rel_rs1E", F_RS1E, 16'd5);
      ex("rel_rdM", F_RDM, 16'd0);
      ex("rel_rdW", F_RDW, 16'd5);
      ex("rel_stallD", F_STD, 16'd0);
      // no hazard: load x5 then reads of x6/x7
      step();
      drv(5'd6, 5'd7, 5'd8, 1'b1, 1'b0, 1'b0);
      ex("nh_rdE", F_RDE, 16'd5);
      ex("nh_mrE", F_MRE, 16'd1);
      ex("nh_stallD", F_STD, 16'd0);
      ex("nh_flushE", F_FLE, 16'd0);
      step();
      drv(5'd1, 5'd2, 5'd0, 1'b1, 1'b1, 1'b0);
      ex("nh_rdE2", F_RDE, 16'd8);
      ex("nh_rs2E", F_RS2E, 16'd7);
      ex("nh_rdM", F_RDM, 16'd5);
      ex("nh_rwM", F_RWM, 16'd1);
      // x0 load followed by x0 reads
      step();
      drv(5'd0, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0);
      ex("nh_rdW", F_RDW, 16'd5);
      ex("nh_rwW", F_RWW, 16'd1);
      ex("x0_mrE", F_MRE, 16'd1);
      ex("x0_rdE", F_RDE, 16'd0);
      ex("x0_stallD", F_STD, 16'd0);
      ex("x0_cnt", F_LWC, 16'd1);
      // taken branch
      step();
      drv(5'd1, 5'd1, 5'd10, 1'b1, 1'b0, 1'b1);
      ex("br_rdE_pre", F_RDE, 16'd9);
      ex("br_flushD", F_FLD, 16'd1);
      ex("br_flushE", F_FLE, 16'd1);
      ex("br_stallD", F_STD, 16'd0);
      ex("br_fcnt0", F_FLC, 16'd0);
      step();
      drv(5'd2, 5'd3, 5'd5, 1'b1, 1'b1, 1'b0);
      ex("br_rdE", F_RDE, 16'd0);
      ex("br_rwE", F_RWE, 16'd0);
      ex("br_rs1E", F_RS1E, 16'd0);
      ex("br_fcnt1", F_FLC, 16'd1);
      ex("br_flushD0", F_FLD, 16'd0);
      // load-use and branch together
      step();
      drv(5'd0, 5'd5, 5'd11, 1'b1, 1'b0, 1'b1);
      ex("sim_stallF", F_STF, 16'd0);
      ex("sim_stallD", F_STD, 16'd0);
      ex("sim_flushD", F_FLD, 16'd1);
      ex("sim_flushE", F_FLE, 16'd1);
      ex("sim_lwc", F_LWC, 16'd1);
      step();
      drv(5'd0, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0);
      ex("sim_lwc2", F_LWC, 16'd1);
      ex("sim_fcnt", F_FLC, 16'd2);
      ex("sim_rdE", F_RDE, 16'd0);
      // async reset in the middle of a load-use stall
      step();
      drv(5'd5, 5'd0, 5'd12, 1'b1, 1'b0, 1'b0);
      #1;
      rst = 1'b0;
      ex("ar_rdE", F_RDE, 16'd0);
      ex("ar_mrE", F_MRE, 16'd0);
      ex("ar_rdM", F_RDM, 16'd0);
      ex("ar_rwM", F_RWM, 16'd0);
      ex("ar_rdW", F_RDW, 16'd0);
      ex("ar_stallF", F_STF, 16'd0);
      ex("ar_stallD", F_STD, 16'd0);
      ex("ar_flushE", F_FLE, 16'd0);
      ex("ar_lwc", F_LWC, 16'd0);
      ex("ar_fcnt", F_FLC, 16'd0);
      @(negedge clk);
      #2;
      rst = 1'b1;
      step();
      drv(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      ex("post_rdE", F_RDE, 16'd12);
      ex("post_rs1E", F_RS1E, 16'd5);
      ex("post_stallD", F_STD, 16'd0);
      ex("post_lwc", F_LWC, 16'd0);
      // counter saturation
      step();
      drv(5'd0, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0);
      force dut.lwstall_cnt_q = 16'hFFFE;
      force dut.flush_cnt_q   = 16'hFFFF;
      #1;
      release dut.lwstall_cnt_q;
      release dut.flush_cnt_q;
      ex("sat_pre", F_LWC, 16'hFFFE);
      step();
      drv(5'd5, 5'd0, 5'd13, 1'b1, 1'b0, 1'b0);
      ex("sat_stallD", F_STD, 16'd1);
      ex("sat_lwc_fe", F_LWC, 16'hFFFE);
      ex("sat_fcnt_ff", F_FLC, 16'hFFFF);
      step();
      drv(5'd0, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0);
      ex("sat_lwc_ff", F_LWC, 16'hFFFF);
      ex("sat_stall0", F_STD, 16'd0);
      step();
      drv(5'd5, 5'd0, 5'd14, 1'b1, 1'b0, 1'b0);
      ex("sat_stall2", F_STD, 16'd1);
      step();
      drv(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
      ex("sat_lwc_hold", F_LWC, 16'hFFFF);
      ex("sat_fcnt_pre", F_FLC, 16'hFFFF);
      step();
      drv(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      ex("sat_fcnt_hold", F_FLC, 16'hFFFF);
      ex("sat_lwc_end", F_LWC, 16'hFFFF);
      @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      done = 1'b1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #20000;
      if (!done) begin
         $display("FAIL timeout: got running expected done");
         $fatal(1, "timeout");
      end
   end
endmodule
